// File: rtl/decoder_seq.sv
// decoder_seq: registered one-hot decoder with enable,
// direct (valid/ready) and self-scanning modes.
module decoder_seq #(
   parameter int SEL_W   = 3,
   parameter int DWELL_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                mode,
   input  logic [SEL_W-1:0]    sel,
   input  logic                sel_valid,
   output logic                sel_ready,
   input  logic [DWELL_W-1:0]  dwell,
   output logic [2**SEL_W-1:0] d,
   output logic [SEL_W-1:0]    idx,
   output logic                wrap,
   output logic                busy
);

   localparam int OUT_W = 2**SEL_W;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [OUT_W-1:0]   d_q, d_d;
   logic [SEL_W-1:0]   idx_q, idx_d;
   logic               wrap_q, wrap_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [DWELL_W-1:0] hold_q, hold_d;
   logic [SEL_W-1:0]   idx_nx;

   assign idx_nx = idx_q + SEL_W'(1);

   always_comb begin
      state_d = state_q;
      d_d     = d_q;
      idx_d   = idx_q;
      wrap_d  = 1'b0;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      if (!en) begin
         state_d = IDLE;
         d_d     = '0;
         idx_d   = '0;
         cnt_d   = '0;
      end else if (!mode) begin
         state_d = DIRECT;
         cnt_d   = '0;
         if (state_q != DIRECT) begin
            d_d   = '0;
            idx_d = '0;
         end else if (sel_valid) begin
            d_d   = OUT_W'(1) << sel;
            idx_d = sel;
         end
      end else begin
         state_d = SCAN;
         if (state_q != SCAN) begin
            d_d    = OUT_W'(1);
            idx_d  = '0;
            cnt_d  = '0;
            hold_d = dwell;
         end else if (cnt_q == hold_q) begin
            // dwell is only re-sampled at a position boundary
            idx_d  = idx_nx;
            d_d    = OUT_W'(1) << idx_nx;
            cnt_d  = '0;
            hold_d = dwell;
            wrap_d = (idx_q == SEL_W'(OUT_W-1));
         end else begin
            cnt_d = cnt_q + DWELL_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         d_q     <= '0;
         idx_q   <= '0;
         wrap_q  <= 1'b0;
         cnt_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         d_q     <= d_d;
         idx_q   <= idx_d;
         wrap_q  <= wrap_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
      end
   end

   assign sel_ready = (state_q == DIRECT) && en && !mode;
   assign busy      = (state_q != IDLE);
   assign d         = d_q;
   assign idx       = idx_q;
   assign wrap      = wrap_q;

endmodule

// File: tb/tb_decoder_seq.sv
// tb_decoder_seq: directed checks of direct decode, scan dwell,
// wrap pulse, mode switching and asynchronous reset.
module tb_decoder_seq;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       mode;
   logic [2:0] sel;
   logic       sel_valid;
   logic       sel_ready;
   logic [3:0] dwell;
   logic [7:0] d;
   logic [2:0] idx;
   logic       wrap;
   logic       busy;

   int n_pass;
   int n_total;

   decoder_seq #(.SEL_W(3), .DWELL_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .mode      (mode),
      .sel       (sel),
      .sel_valid (sel_valid),
      .sel_ready (sel_ready),
      .dwell     (dwell),
      .d         (d),
      .idx       (idx),
      .wrap      (wrap),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      n_pass    = 0;
      n_total   = 0;
      rst_n     = 1'b0;
      en        = 1'b0;
      mode      = 1'b0;
      sel       = '0;
      sel_valid = 1'b0;
      dwell     = '0;
      tick();
      tick();
      chk("rst_d", 32'(d), 32'h0);
      chk("rst_idx", 32'(idx), 32'h0);
      chk("rst_wrap", 32'(wrap), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_ready", 32'(sel_ready), 32'h0);

      // 1: direct, back-to-back transfers
      rst_n = 1'b1;
      en    = 1'b1;
      tick();
      chk("dir_entry_d", 32'(d), 32'h0);
      chk("dir_entry_busy", 32'(busy), 32'h1);
      chk("dir_entry_ready", 32'(sel_ready), 32'h1);
      sel_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         sel = 3'(i);
         tick();
         chk("b2b_d", 32'(d), 32'h1 << i);
         chk("b2b_idx", 32'(idx), 32'(i));
         chk("b2b_ready", 32'(sel_ready), 32'h1);
      end

      // 2: hold without transfer, then disable
      sel = 3'd5;
      tick();
      chk("acc5_d", 32'(d), 32'h20);
      sel_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sel = 3'(i + 1);
         tick();
         chk("hold_d", 32'(d), 32'h20);
         chk("hold_idx", 32'(idx), 32'h5);
      end
      en = 1'b0;
      tick();
      chk("dis_d", 32'(d), 32'h0);
      chk("dis_idx", 32'(idx), 32'h0);
      chk("dis_ready", 32'(sel_ready), 32'h0);
      chk("dis_busy", 32'(busy), 32'h0);

      // 3: scan with dwell=0 and wrap
      en    = 1'b1;
      mode  = 1'b1;
      dwell = 4'd0;
      tick();
      chk("scan0_d", 32'(d), 32'h01);
      chk("scan0_idx", 32'(idx), 32'h0);
      chk("scan0_wrap", 32'(wrap), 32'h0);
      for (int i = 1; i < 8; i++) begin
         tick();
         chk("scan_d", 32'(d), 32'h1 << i);
         chk("scan_idx", 32'(idx), 32'(i));
         chk("scan_wrap", 32'(wrap), 32'h0);
      end
      tick();
      chk("wrap_d", 32'(d), 32'h01);
      chk("wrap_idx", 32'(idx), 32'h0);
      chk("wrap_pulse", 32'(wrap), 32'h1);
      tick();
      chk("postwrap_d", 32'(d), 32'h02);
      chk("postwrap_wrap", 32'(wrap), 32'h0);

      // 4: dwell=2, then dwell=0 mid-position
      en = 1'b0;
      tick();
      en    = 1'b1;
      dwell = 4'd2;
      tick();
      chk("dw2_a0", 32'(d), 32'h01);
      tick();
      chk("dw2_a1", 32'(d), 32'h01);
      tick();
      chk("dw2_a2", 32'(d), 32'h01);
      tick();
      chk("dw2_b0", 32'(d), 32'h02);
      dwell = 4'd0;
      tick();
      chk("dw2_b1", 32'(d), 32'h02);
      tick();
      chk("dw2_b2", 32'(d), 32'h02);
      tick();
      chk("dw0_c", 32'(d), 32'h04);
      tick();
      chk("dw0_d", 32'(d), 32'h08);
      tick();
      chk("dw0_e", 32'(d), 32'h10);
      chk("dw0_e_idx", 32'(idx), 32'h4);

      // 5: switch to direct at idx 4, then restart scan
      mode = 1'b0;
      tick();
      chk("sw_dir_d", 32'(d), 32'h0);
      chk("sw_dir_idx", 32'(idx), 32'h0);
      chk("sw_dir_ready", 32'(sel_ready), 32'h1);
      mode = 1'b1;
      tick();
      chk("restart_d", 32'(d), 32'h01);
      chk("restart_idx", 32'(idx), 32'h0);
      chk("restart_ready", 32'(sel_ready), 32'h0);
      tick();
      chk("restart_d1", 32'(d), 32'h02);

      // 6: asynchronous reset mid-scan
      for (int i = 0; i < 5; i++) tick();
      chk("pre_rst_idx", 32'(idx), 32'h6);
      chk("pre_rst_d", 32'(d), 32'h40);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_d", 32'(d), 32'h0);
      chk("arst_idx", 32'(idx), 32'h0);
      chk("arst_wrap", 32'(wrap), 32'h0);
      chk("arst_busy", 32'(busy), 32'h0);
      tick();
      chk("arst_hold_d", 32'(d), 32'h0);
      rst_n = 1'b1;
      tick();
      chk("rel_d", 32'(d), 32'h01);
      chk("rel_idx", 32'(idx), 32'h0);
      tick();
      chk("rel_d1", 32'(d), 32'h02);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/decoder_seq.md
Name: decoder_seq

Overview:
- Parametrised registered SEL_W-to-2^SEL_W one-hot decoder with enable. Next generation of the team's 3-to-8 decoder.
- Two modes:
  - Direct: a select code is accepted over a valid/ready handshake and decoded to a registered one-hot output.
  - Scan: the block walks the one-hot output through every position itself, holding each position for a programmable dwell time.
- Used as a channel or row selector driven either by control logic or by its own sweep.

Parameters:
SEL_W, 3, select width; output width OUT_W = 2**SEL_W (derived localparam, not overridable)
DWELL_W, 4, width of the dwell-time input and the internal dwell counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  block enable; 0 forces outputs to zero
mode  input  1  0 = direct decode, 1 = auto-scan
sel  input  SEL_W  select code (direct mode)
sel_valid  input  1  sel is valid this cycle
sel_ready  output  1  block accepts sel this cycle
dwell  input  DWELL_W  scan hold time per position, in cycles minus one
d  output  OUT_W  registered one-hot decoded output (all-zero when idle)
idx  output  SEL_W  registered index of the currently asserted bit of d
wrap  output  1  one-cycle pulse when the scan wraps from OUT_W-1 to 0
busy  output  1  state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous) sets state=IDLE, d=0, idx=0, wrap=0, dwell counter=0. All registered outputs stay zero until after the first rising edge with rst_n high.
- States: IDLE, DIRECT, SCAN. The state register is sampled every rising edge.
- Transitions, evaluated in priority order each edge:
  - en=0: next state IDLE, d=0, idx=0, dwell counter cleared.
  - en=1, mode=0: next state DIRECT.
  - en=1, mode=1: next state SCAN.
- IDLE: d=0, sel_ready=0, wrap=0.
- sel_ready is combinational: (state==DIRECT) && en && !mode. No transfer can be accepted in a cycle in which the block is leaving DIRECT.
- DIRECT:
  - Entry from IDLE or SCAN: d=0, idx=0 on the entering edge.
  - Transfer = sel_valid && sel_ready at a rising edge. On that edge d <= 1<<sel and idx <= sel, so latency is 1 cycle from acceptance.
  - With no transfer, d and idx hold.
  - Back-to-back transfers are allowed at one per cycle.
- SCAN:
  - Entry edge: d <= 1<<0, idx <= 0, dwell counter <= 0, and dwell is latched into a hold register.
  - Each following edge: if counter == held dwell, advance idx <= idx+1 (modulo OUT_W), d <= 1<<(idx+1), counter <= 0, and re-latch dwell. Otherwise counter <= counter+1.
  - Each position is therefore held for dwell+1 cycles. dwell=0 advances every cycle.
  - A change to dwell takes effect at the next position boundary only.
- Wrap: when the scan advances from idx=OUT_W-1 to 0, wrap=1 for exactly that one cycle, coincident with d becoming 1. wrap is 0 at all other times, including on SCAN entry.
- Mode change while en=1: takes effect at the next edge with the entry behaviour above. A scan that is restarted always begins at idx 0.
- en or mode toggling mid-scan discards the scan position. No partial state is retained.
- Invariant: d is either all-zero (IDLE, or DIRECT before its first transfer) or exactly one-hot with the set bit equal to idx.
- Asserting rst_n low at any time, including mid-transfer or mid-scan, immediately zeroes all outputs.

Test Plan:
1. Reset, then en=1, mode=0, SEL_W=3; accept sel=0..7 on consecutive cycles with sel_valid=1 -> d = 0x01,0x02,...,0x80, each 1 cycle after acceptance; idx tracks sel; sel_ready stays 1.
2. Direct mode, sel=5 accepted, then sel_valid=0 for 4 cycles with sel changing -> d holds 0x20 and idx holds 5; then en=0 -> next cycle d=0, sel_ready=0, busy=0.
3. en=1, mode=1, dwell=0 -> d steps 0x01,0x02,...,0x80,0x01 on successive cycles; wrap=1 only in the cycle d returns to 0x01.
4. Scan with dwell=2 -> each position held exactly 3 cycles; change dwell to 0 mid-position -> the current position still holds 3 cycles, subsequent positions hold 1 cycle.
5. Scan reaches idx=4, then mode=0 -> next cycle d=0, sel_ready=1; set mode=1 again -> scan restarts at d=0x01, idx=0.
6. Pull rst_n low asynchronously (between edges) mid-scan at idx=6 -> d=0, idx=0, wrap=0 immediately; after release with en=1, mode=1 -> scan restarts from 0x01.
